// File: rtl/if_fetch_stage_if.sv
// I-cache fetch port shared by the fetch stage (master) and the instruction cache (slave).
interface if_fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_ready, inst_rvalid, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_ready, inst_rvalid, inst_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, one outstanding I-cache request, redirects and ADEF.
// Optional stall counter enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int          CAUSE_W  = 7,
  parameter logic [CAUSE_W-1:0] EXC_NOP  = 7'h00,
  parameter logic [CAUSE_W-1:0] EXC_ADEF = 7'h08
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             pause,
  input  logic                   branch_flush,
  input  logic [31:0]            branch_target_addr,
  input  logic                   exception_flush,
  input  logic [31:0]            exception_new_pc,
  if_fetch_stage_if.master       icache,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst,
  output logic [4:0]             if_is_exception,
  output logic [5*CAUSE_W-1:0]   if_exception_cause,
  output logic                   pause_request_if
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_CANCEL = 2'd2
  } state_e;

  state_e      state_r;
  logic [31:0] pc_r;
  logic        out_valid_r;
  logic        skid_valid_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_inst_r;
  logic        skid_exc_r;
  logic        adef_done_r;

  logic        redirect_s;
  logic [31:0] target_s;
  logic        misaligned_s;
  logic        consume_s;
  logic        out_free_s;
  logic        req_s;
  logic        accept_s;
  logic        adef_s;
  logic        ret_s;
  logic        new_valid_s;
  logic [31:0] new_inst_s;
  logic        cancel_s;
  logic        unused_pause_s;

  function automatic logic [5*CAUSE_W-1:0] cause_vec(input logic exc);
    cause_vec = exc ? {EXC_ADEF, {4{EXC_NOP}}} : {5{EXC_NOP}};
  endfunction

  assign redirect_s   = exception_flush | branch_flush;
  assign target_s     = exception_flush ? exception_new_pc : branch_target_addr;
  assign misaligned_s = (pc_r[1:0] != 2'b00);
  assign consume_s    = out_valid_r & ~pause[1];
  assign out_free_s   = ~out_valid_r | consume_s;
  assign req_s        = (state_r == ST_REQ) & ~rst & ~pause[0] & ~skid_valid_r & ~misaligned_s;
  assign accept_s     = req_s & icache.inst_ready;
  // A misaligned PC yields a single ADEF entry, then fetch idles until a redirect.
  assign adef_s       = (state_r == ST_REQ) & misaligned_s & ~adef_done_r & ~pause[0] & ~skid_valid_r;
  assign ret_s        = (state_r == ST_WAIT) & icache.inst_rvalid;
  assign new_valid_s  = adef_s | ret_s;
  assign new_inst_s   = ret_s ? icache.inst_rdata : 32'h0000_0000;
  // A response still owed to an abandoned request must be swallowed after the redirect.
  assign cancel_s     = accept_s
                      | ((state_r == ST_WAIT)   & ~icache.inst_rvalid)
                      | ((state_r == ST_CANCEL) & ~icache.inst_rvalid);

  assign icache.inst_req  = req_s;
  assign icache.inst_addr = pc_r;
  assign pause_request_if = ~out_valid_r & ~branch_flush & ~exception_flush;
  assign unused_pause_s   = ^pause[5:2];

  // Fetch FSM, PC, output register and skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_REQ;
      pc_r               <= RESET_PC;
      out_valid_r        <= 1'b0;
      skid_valid_r       <= 1'b0;
      skid_pc_r          <= 32'h0000_0000;
      skid_inst_r        <= 32'h0000_0000;
      skid_exc_r         <= 1'b0;
      adef_done_r        <= 1'b0;
      if_pc              <= RESET_PC;
      if_inst            <= 32'h0000_0000;
      if_is_exception    <= 5'b00000;
      if_exception_cause <= cause_vec(1'b0);
    end else if (redirect_s) begin
      state_r            <= cancel_s ? ST_CANCEL : ST_REQ;
      pc_r               <= target_s;
      out_valid_r        <= 1'b0;
      skid_valid_r       <= 1'b0;
      adef_done_r        <= 1'b0;
      if_pc              <= RESET_PC;
      if_inst            <= 32'h0000_0000;
      if_is_exception    <= 5'b00000;
      if_exception_cause <= cause_vec(1'b0);
    end else begin
      case (state_r)
        ST_REQ:    state_r <= accept_s ? ST_WAIT : ST_REQ;
        ST_WAIT:   state_r <= icache.inst_rvalid ? ST_REQ : ST_WAIT;
        ST_CANCEL: state_r <= icache.inst_rvalid ? ST_REQ : ST_CANCEL;
        default:   state_r <= ST_REQ;
      endcase
      pc_r        <= ret_s ? pc_r + 32'd4 : pc_r;
      adef_done_r <= adef_done_r | adef_s;
      // New entries only appear with the skid empty, so skid drain and load never collide.
      if (new_valid_s) begin
        if (out_free_s) begin
          out_valid_r        <= 1'b1;
          if_pc              <= pc_r;
          if_inst            <= new_inst_s;
          if_is_exception    <= {adef_s, 4'b0000};
          if_exception_cause <= cause_vec(adef_s);
        end else begin
          skid_valid_r <= 1'b1;
          skid_pc_r    <= pc_r;
          skid_inst_r  <= new_inst_s;
          skid_exc_r   <= adef_s;
        end
      end else if (consume_s) begin
        if (skid_valid_r) begin
          skid_valid_r       <= 1'b0;
          if_pc              <= skid_pc_r;
          if_inst            <= skid_inst_r;
          if_is_exception    <= {skid_exc_r, 4'b0000};
          if_exception_cause <= cause_vec(skid_exc_r);
        end else begin
          out_valid_r <= 1'b0;
        end
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating count of cycles in which IF asks for a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_stall_cnt <= 32'h0000_0000;
    end else if (pause_request_if && (fetch_stall_cnt != 32'hFFFF_FFFF)) begin
      fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end else begin
      fetch_stall_cnt <= fetch_stall_cnt;
    end
  end
`endif

endmodule
